// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter that sequences one requester's write (and optional readback check) onto the PIO slave.
// Latency: WRITE in the cycle after the grant edge, ack 3 cycles after it (2 with VERIFY=0), then one IDLE cycle.
// Backpressure: requests are levels held until ack; a request seen while busy waits for the next IDLE cycle.
module pio_write_arbiter #(
    parameter int DATA_W = 12,
    parameter bit VERIFY = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic [1:0]        pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [31:0]       pio_writedata,
    input  logic [31:0]       pio_readdata,
    output logic              busy,
    output logic              last_grant,
    output logic              verify_err,
    input  logic              err_clr,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] hold;
    logic              grant_nxt;
    logic              any_req;
    logic              mismatch;
    logic              unused_rd_hi;

    assign any_req      = req0 | req1;
    // On contention the requester that did not win last time goes next.
    assign grant_nxt    = (req0 && req1) ? ~last_grant : req1;
    assign mismatch     = (pio_readdata[DATA_W-1:0] != hold);
    assign unused_rd_hi = ^pio_readdata[31:DATA_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = WRITE;
            WRITE:   state_nxt = (VERIFY != 1'b0) ? READ : ACK;
            READ:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold       <= '0;
            last_grant <= 1'b1;
            verify_err <= 1'b0;
            wr_count   <= 16'h0000;
        end else begin
            if (state == IDLE && any_req) begin
                last_grant <= grant_nxt;
                hold       <= grant_nxt ? data1 : data0;
            end
            // A mismatch at the same edge as err_clr keeps the flag set.
            if (state == READ && mismatch) begin
                verify_err <= 1'b1;
            end else if (err_clr) begin
                verify_err <= 1'b0;
            end
            if (state == ACK) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    always_comb begin
        busy           = (state != IDLE);
        ack0           = (state == ACK) && !last_grant;
        ack1           = (state == ACK) && last_grant;
        pio_address    = 2'b00;
        pio_chipselect = (state == WRITE) || (state == READ);
        pio_write_n    = (state != WRITE);
        pio_writedata  = '0;
        if (state == WRITE) begin
            pio_writedata = {{(32-DATA_W){1'b0}}, hold};
        end
    end

endmodule
